// File: rtl/ps2_dev_tx.sv
// ---------------------------------------------------------------------------
// PS2DevTx : PS/2 device-side transmitter
//
// Accepts scan-code bytes into a small FIFO and serialises each one as an
// 11-bit PS/2 frame (start 0, data LSB first, odd parity, stop 1) on the
// device clock/data lines. Data only changes while ps2_clk_o is high, and a
// fixed idle gap separates consecutive frames.
//
// Ports
//   clk_i       : system clock, all logic on its rising edge
//   rst_n_i     : synchronous active-low reset
//   tx_data_i   : byte to transmit
//   tx_valid_i  : tx_data_i is valid; accepted when tx_ready_o is high
//   tx_ready_o  : FIFO has room for another byte
//   ps2_clk_o   : PS/2 device clock, idle high
//   ps2_dat_o   : PS/2 device data, idle high
//   busy_o      : transmitter is not idle
//   fifo_cnt_o  : current FIFO occupancy
// ---------------------------------------------------------------------------
module ps2_dev_tx #(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_CYC    = 5000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          ps2_clk_o,
  output logic                          ps2_dat_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int MAX_PH = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW     = $clog2(MAX_PH);

  localparam logic [CW-1:0] DIV_LOAD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] PH_ONE    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]    LAST_BIT  = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    GAP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] phase;
  logic [CW-1:0] phase_next;
  logic [3:0]    idx;
  logic [3:0]    idx_next;
  logic [10:0]   frame;
  logic [10:0]   frame_next;
  logic          clk_q;
  logic          dat_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    head;
  logic          push;
  logic          pop;

  assign tx_ready_o = (count != CNT_FULL);
  assign push       = tx_valid_i && tx_ready_o;
  assign head       = mem[rd_ptr];
  assign fifo_cnt_o = count;
  assign busy_o     = (state != IDLE);
  assign ps2_clk_o  = clk_q;
  assign ps2_dat_o  = dat_q;

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push) begin
      mem[wr_ptr] <= tx_data_i;
    end
  end

  // FIFO pointers and occupancy. Depth is a power of two, so the pointers
  // wrap naturally; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Frame sequencer. The single phase counter is reloaded with (length - 1)
  // on every state entry and counts down; the state ends when it reaches 0.
  // The frame is latched at pop time, so later FIFO writes cannot touch it.
  always_comb begin
    state_next = state;
    phase_next = phase;
    idx_next   = idx;
    frame_next = frame;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          frame_next = {1'b1, ~^head, head, 1'b0};
          idx_next   = '0;
          phase_next = DIV_LOAD;
          state_next = HI;
        end
      end
      HI: begin
        if (phase == '0) begin
          phase_next = DIV_LOAD;
          state_next = LO;
        end else begin
          phase_next = phase - PH_ONE;
        end
      end
      LO: begin
        if (phase == '0) begin
          if (idx < LAST_BIT) begin
            idx_next   = idx + 4'd1;
            phase_next = DIV_LOAD;
            state_next = HI;
          end else begin
            phase_next = GAP_LOAD;
            state_next = GAP;
          end
        end else begin
          phase_next = phase - PH_ONE;
        end
      end
      GAP: begin
        if (phase == '0) begin
          state_next = IDLE;
        end else begin
          phase_next = phase - PH_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus registered line drivers. The lines are derived from
  // the next-state values so they change on the same edge as the state,
  // while staying glitch-free at the pins.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      phase <= '0;
      idx   <= '0;
      frame <= '1;
      clk_q <= 1'b1;
      dat_q <= 1'b1;
    end else begin
      state <= state_next;
      phase <= phase_next;
      idx   <= idx_next;
      frame <= frame_next;
      clk_q <= (state_next != LO);
      dat_q <= (state_next == HI || state_next == LO) ? frame_next[idx_next] : 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_dev_tx : self-checking bench for ps2_dev_tx
//
// Accepted bytes are pushed onto a scoreboard queue; a receiver model watches
// the PS/2 lines, rebuilds each frame on ps2_clk falling edges, and pops the
// queue to compare. Timing of edges, frame length and inter-frame gap are
// checked against the configured CLK_DIV / GAP_CYC.
// ---------------------------------------------------------------------------
module tb_ps2_dev_tx;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYC    = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic             ps2_clk;
  logic             ps2_dat;
  logic             busy;
  logic [CNT_W-1:0] fifo_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q [$];
  logic [10:0] rx_frames [$];

  int          cyc = 0;
  int          nbits = 0;
  int          frames_done = 0;
  int          fall_total = 0;
  int          pop_cyc = 0;
  int          hi_cyc = 0;
  int          gap_cyc = 0;
  int          last_fall = 0;
  int          last_spacing = -1;
  logic        prev_clk = 1'b1;
  logic        prev_dat = 1'b1;
  logic        prev_busy = 1'b0;
  logic [10:0] bits = '0;

  ps2_dev_tx #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYC    (GAP_CYC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .ps2_clk_o  (ps2_clk),
    .ps2_dat_o  (ps2_dat),
    .busy_o     (busy),
    .fifo_cnt_o (fifo_cnt)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Receiver model, sampled 1 time unit after each rising edge. It rebuilds
  // frames from data seen at ps2_clk falling edges and checks edge timing.
  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    cyc++;
    if (!rst_n) begin
      nbits     = 0;
      prev_clk  = 1'b1;
      prev_dat  = 1'b1;
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        hi_cyc = cyc;
        checkOutput("hi_after_pop", cyc - pop_cyc, 1);
        last_spacing = cyc - gap_cyc;
      end
      if (!busy) begin
        checkOutput("idle_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        if (fifo_cnt != '0) pop_cyc = cyc;
      end
      if (prev_clk && !ps2_clk) begin
        fall_total++;
        if (nbits == 0) checkOutput("first_fall_delay", cyc - pop_cyc, 1 + CLK_DIV);
        else checkOutput("fall_spacing", cyc - last_fall, 2 * CLK_DIV);
        last_fall = cyc;
        if (nbits >= 11) begin
          checkOutput("extra_fall", nbits, 10);
        end else begin
          bits[nbits] = ps2_dat;
          nbits++;
          if (nbits == 11) begin
            frames_done++;
            rx_frames.push_back(bits);
            checkOutput("odd_parity", {31'd0, ^bits[9:1]}, 1);
            if (exp_q.size() == 0) begin
              checkOutput("unexpected_frame", 1, 0);
            end else begin
              e = exp_q.pop_front();
              checkOutput("frame_bits", bits, {1'b1, ~^e, e, 1'b0});
            end
          end
        end
      end else if (!prev_clk && !ps2_clk) begin
        checkOutput("dat_stable_low", ps2_dat, prev_dat);
      end else if (!prev_clk && ps2_clk && nbits == 11) begin
        gap_cyc = cyc;
        checkOutput("frame_len", cyc - hi_cyc, 11 * 2 * CLK_DIV);
        nbits = 0;
      end
      prev_clk  = ps2_clk;
      prev_dat  = ps2_dat;
      prev_busy = busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offers one byte and records it on the scoreboard once it is accepted.
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready) checkOutput("push_timeout", 0, 1);
    else exp_q.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic waitFrames(input int target);
    int waited;
    waited = 0;
    while (frames_done < target && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("wait_frames", frames_done, target);
  endtask

  task automatic waitIdle();
    int waited;
    waited = 0;
    while ((busy || fifo_cnt != '0) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("wait_idle", {30'd0, busy, fifo_cnt == '0}, 32'd1);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          fr0;
    int          f0;
    int          accepted;
    int          idx;
    int          waited;
    logic [7:0]  bytes [6];
    logic [10:0] fr;

    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset values.
    rst_n = 1'b0;
    tick(3);
    checkOutput("rst_ready", tx_ready, 1);
    checkOutput("rst_clk", ps2_clk, 1);
    checkOutput("rst_dat", ps2_dat, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cnt", fifo_cnt, 0);
    rst_n = 1'b1;
    tick(2);
    checkOutput("post_rst_ready", tx_ready, 1);

    // Single byte 0x1C: exact bit pattern and edge count.
    $display("[TB] single byte 0x1C");
    f0  = fall_total;
    fr0 = frames_done;
    applyStimulus(8'h1C);
    waitFrames(fr0 + 1);
    waitIdle();
    checkOutput("t1_fall_count", fall_total - f0, 11);
    fr = rx_frames[fr0];
    checkOutput("t1_frame", fr, 11'b10000111000);

    // 0x00 then 0xFF: parity bits and inter-frame spacing.
    $display("[TB] parity and gap");
    fr0 = frames_done;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    waitFrames(fr0 + 2);
    waitIdle();
    fr = rx_frames[fr0];
    checkOutput("t2_data0", fr[8:1], 8'h00);
    checkOutput("t2_parity0", fr[9], 1);
    fr = rx_frames[fr0 + 1];
    checkOutput("t2_dataff", fr[8:1], 8'hFF);
    checkOutput("t2_parityff", fr[9], 1);
    checkOutput("t2_gap_spacing", last_spacing, GAP_CYC + 1);

    // Valid held high for 6 bytes while a frame is active.
    $display("[TB] fifo fill");
    fr0      = frames_done;
    accepted = 0;
    idx      = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (idx < 6) begin
        tx_data  = bytes[idx];
        tx_valid = 1'b1;
        if (tx_ready) begin
          exp_q.push_back(bytes[idx]);
          idx++;
          accepted++;
        end
      end
    end
    checkOutput("t3_accepted", accepted, 5);
    checkOutput("t3_ready_low", tx_ready, 0);
    checkOutput("t3_cnt_full", fifo_cnt, FIFO_DEPTH);
    @(negedge clk);
    tx_valid = 1'b0;
    waitFrames(fr0 + 5);
    waitIdle();
    for (int k = 0; k < 5; k++) begin
      fr = rx_frames[fr0 + k];
      checkOutput("t3_order", fr[8:1], bytes[k]);
    end

    // Simultaneous push and pop with two bytes stored.
    $display("[TB] push and pop together");
    fr0 = frames_done;
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    applyStimulus(8'hA3);
    checkOutput("t4_cnt_before", fifo_cnt, 2);
    waited = 0;
    while (busy && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("t4_idle_reached", busy, 0);
    tx_data  = 8'hA4;
    tx_valid = 1'b1;
    if (tx_ready) exp_q.push_back(8'hA4);
    @(negedge clk);
    tx_valid = 1'b0;
    checkOutput("t4_cnt_same", fifo_cnt, 2);
    checkOutput("t4_busy", busy, 1);
    waitFrames(fr0 + 4);
    waitIdle();
    fr = rx_frames[fr0 + 1];
    checkOutput("t4_order1", fr[8:1], 8'hA2);
    fr = rx_frames[fr0 + 3];
    checkOutput("t4_order3", fr[8:1], 8'hA4);

    // Reset pulse during bit 5 aborts the frame and empties the FIFO.
    $display("[TB] reset mid-frame");
    fr0 = frames_done;
    applyStimulus(8'hB1);
    applyStimulus(8'hB2);
    applyStimulus(8'hB3);
    waited = 0;
    while (!(nbits == 5 && ps2_clk) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("t5_reached_bit5", nbits, 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    checkOutput("t5_clk", ps2_clk, 1);
    checkOutput("t5_dat", ps2_dat, 1);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_cnt", fifo_cnt, 0);
    checkOutput("t5_ready", tx_ready, 1);
    f0 = fall_total;
    tick(200);
    checkOutput("t5_no_edges", fall_total - f0, 0);
    checkOutput("t5_no_frames", frames_done, fr0);
    checkOutput("t5_still_idle", busy, 0);
    applyStimulus(8'h5A);
    waitFrames(fr0 + 1);
    waitIdle();

    // Receiver loopback sequence 0xF0, 0x1C.
    $display("[TB] loopback sequence");
    fr0 = frames_done;
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    waitFrames(fr0 + 2);
    waitIdle();
    fr = rx_frames[fr0];
    checkOutput("t6_f0", fr, 11'b11111100000);
    fr = rx_frames[fr0 + 1];
    checkOutput("t6_1c", fr, 11'b10000111000);
    checkOutput("t6_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
